// File: rtl/target_hit_detector.sv
// target_hit_detector: checks the snake head against the current target on each
// move tick. On a hit it sends a one-cycle REACHED_TARGET pulse, steps the BCD
// score and the snake length, and holds WIN_GAME high once the score reaches
// WIN_SCORE.
module target_hit_detector #(
  parameter int WIN_SCORE   = 10,
  parameter int INIT_LENGTH = 3,
  parameter int MAX_LENGTH  = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MSM_State,
  input  logic        MOVE_TICK,
  input  logic [7:0]  HEAD_X,
  input  logic [6:0]  HEAD_Y,
  input  logic [14:0] TARGET_ADDR,
  output logic        REACHED_TARGET,
  output logic [3:0]  SCORE_TENS,
  output logic [3:0]  SCORE_ONES,
  output logic [7:0]  SNAKE_LENGTH,
  output logic        WIN_GAME
);

  localparam logic [6:0] WIN_SCORE_L   = 7'(WIN_SCORE);
  localparam logic [7:0] INIT_LENGTH_L = 8'(INIT_LENGTH);
  localparam logic [7:0] MAX_LENGTH_L  = 8'(MAX_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HIT,
    ST_WON
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        take_hit;
  logic        msm_idle;
  logic        msm_play;
  logic        target_match;
  logic [3:0]  tens_inc;
  logic [3:0]  ones_inc;
  logic [6:0]  score_inc_bin;
  logic [7:0]  length_inc;

  assign msm_idle      = (MSM_State == 2'b00);
  assign msm_play      = (MSM_State == 2'b01);
  assign target_match  = ({HEAD_X, HEAD_Y} == TARGET_ADDR);
  assign score_inc_bin = ({3'b000, tens_inc} * 7'd10) + {3'b000, ones_inc};
  assign length_inc    = (SNAKE_LENGTH >= MAX_LENGTH_L) ? SNAKE_LENGTH
                                                        : SNAKE_LENGTH + 8'd1;

  // BCD score plus one, holding at 99 instead of wrapping
  always_comb begin
    tens_inc = SCORE_TENS;
    ones_inc = SCORE_ONES;
    if (!(SCORE_TENS == 4'd9 && SCORE_ONES == 4'd9)) begin
      if (SCORE_ONES == 4'd9) begin
        ones_inc = 4'd0;
        tens_inc = SCORE_TENS + 4'd1;
      end else begin
        ones_inc = SCORE_ONES + 4'd1;
      end
    end
  end

  // Next state; MSM IDLE wins over everything, including a hit in the same cycle
  always_comb begin
    state_next = state;
    take_hit   = 1'b0;
    if (msm_idle) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (msm_play) state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (msm_play && MOVE_TICK && target_match) begin
            state_next = ST_HIT;
            take_hit   = 1'b1;
          end
        end
        ST_HIT: begin
          state_next = WIN_GAME ? ST_WON : ST_ARMED;
        end
        ST_WON: begin
          state_next = ST_WON;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Score, length, win flag and hit pulse all change on the edge that enters HIT
  always_ff @(posedge CLK) begin
    if (!RESET || msm_idle) begin
      REACHED_TARGET <= 1'b0;
      SCORE_TENS     <= 4'd0;
      SCORE_ONES     <= 4'd0;
      SNAKE_LENGTH   <= INIT_LENGTH_L;
      WIN_GAME       <= 1'b0;
    end else if (take_hit) begin
      REACHED_TARGET <= 1'b1;
      SCORE_TENS     <= tens_inc;
      SCORE_ONES     <= ones_inc;
      SNAKE_LENGTH   <= length_inc;
      if (score_inc_bin >= WIN_SCORE_L) WIN_GAME <= 1'b1;
    end else begin
      REACHED_TARGET <= 1'b0;
    end
  end

endmodule

// File: tb/tb_target_hit_detector.sv
// Testbench for target_hit_detector: two instances (win at 10 and at 99) share
// the same stimulus and are compared every cycle against a score-keeping model.
module tb_target_hit_detector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  msm = 2'b00;
  logic        tick = 1'b0;
  logic [7:0]  head_x = 8'd0;
  logic [6:0]  head_y = 7'd0;
  logic [14:0] target = 15'd0;

  logic        reached_a, win_a, reached_b, win_b;
  logic [3:0]  tens_a, ones_a, tens_b, ones_b;
  logic [7:0]  len_a, len_b;
  logic [17:0] obs_a, obs_b;

  int vectors = 0;
  int miscompares = 0;

  localparam int INIT_LEN = 3;
  localparam int MAX_LEN  = 32;

  // model of each instance: game running, pulse due, score, length, won
  int win_score [2] = '{10, 99};
  int m_active [2];
  int m_pulse  [2];
  int m_score  [2];
  int m_len    [2];
  int m_won    [2];

  target_hit_detector #(.WIN_SCORE(10), .INIT_LENGTH(3), .MAX_LENGTH(32)) dut_a (
    .CLK(clk), .RESET(reset_n), .MSM_State(msm), .MOVE_TICK(tick),
    .HEAD_X(head_x), .HEAD_Y(head_y), .TARGET_ADDR(target),
    .REACHED_TARGET(reached_a), .SCORE_TENS(tens_a), .SCORE_ONES(ones_a),
    .SNAKE_LENGTH(len_a), .WIN_GAME(win_a));

  target_hit_detector #(.WIN_SCORE(99), .INIT_LENGTH(3), .MAX_LENGTH(32)) dut_b (
    .CLK(clk), .RESET(reset_n), .MSM_State(msm), .MOVE_TICK(tick),
    .HEAD_X(head_x), .HEAD_Y(head_y), .TARGET_ADDR(target),
    .REACHED_TARGET(reached_b), .SCORE_TENS(tens_b), .SCORE_ONES(ones_b),
    .SNAKE_LENGTH(len_b), .WIN_GAME(win_b));

  assign obs_a = {reached_a, tens_a, ones_a, len_a, win_a};
  assign obs_b = {reached_b, tens_b, ones_b, len_b, win_b};

  always #5 clk = ~clk;

  // advance the model by one clock edge using the inputs seen at that edge
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n || msm == 2'b00) begin
        m_active[i] = 0; m_pulse[i] = 0; m_score[i] = 0;
        m_len[i] = INIT_LEN; m_won[i] = 0;
      end else if (m_active[i] == 0) begin
        if (msm == 2'b01) m_active[i] = 1;
      end else if (m_pulse[i] != 0) begin
        m_pulse[i] = 0;
      end else if (m_won[i] == 0 && msm == 2'b01 && tick && {head_x, head_y} == target) begin
        m_pulse[i] = 1;
        if (m_score[i] < 99) m_score[i] = m_score[i] + 1;
        if (m_len[i] < MAX_LEN) m_len[i] = m_len[i] + 1;
        if (m_score[i] >= win_score[i]) m_won[i] = 1;
      end
    end
  endtask

  function automatic logic [17:0] expected(int i);
    return {1'(m_pulse[i]), 4'(m_score[i] / 10), 4'(m_score[i] % 10), 8'(m_len[i]), 1'(m_won[i])};
  endfunction

  // one clock: model follows the edge, outputs sampled at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_target(int x, int y);
    target = {8'(x), 7'(y)};
  endtask

  task automatic head_on_target();
    head_x = target[14:7];
    head_y = target[6:0];
  endtask

  task automatic random_target();
    set_target($urandom_range(159, 0), $urandom_range(119, 0));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; msm = 2'b00; tick = 1'b0;
    step(); step();
    vectors++;
    if (obs_a !== {1'b0, 4'd0, 4'd0, 8'd3, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_a: got %h want %h", obs_a, {1'b0, 4'd0, 4'd0, 8'd3, 1'b0});
    end
    vectors++;
    if (obs_b !== expected(1)) begin
      miscompares++;
      $display("[TB] FAIL reset_b: got %h want %h", obs_b, expected(1));
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_hit();
    msm = 2'b01;
    step();
    set_target(40, 30); head_x = 8'd40; head_y = 7'd30; tick = 1'b1;
    step();
    vectors++;
    if (obs_a !== {1'b1, 4'd0, 4'd1, 8'd4, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL single_hit: got %h want %h", obs_a, {1'b1, 4'd0, 4'd1, 8'd4, 1'b0});
    end
    tick = 1'b0;
    step();
    vectors++;
    if (obs_a !== expected(0)) begin
      miscompares++;
      $display("[TB] FAIL hit_pulse_end: got %h want %h", obs_a, expected(0));
    end
    head_x = 8'd41; tick = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      tick = 1'b0;
      vectors++;
      if (obs_a !== {1'b0, 4'd0, 4'd1, 8'd4, 1'b0} || obs_b !== expected(1)) begin
        miscompares++;
        $display("[TB] FAIL near_miss: got %h/%h want %h/%h", obs_a, obs_b, expected(0), expected(1));
      end
    end
  endtask

  task automatic test_no_tick();
    head_on_target(); tick = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (obs_a !== expected(0) || reached_a !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL no_tick: got %h want %h", obs_a, expected(0));
      end
    end
  endtask

  task automatic test_win();
    msm = 2'b00; step();
    msm = 2'b01; step();
    for (int k = 0; k < 10; k++) begin
      random_target(); head_on_target(); tick = 1'b1;
      step();
      tick = 1'b0;
      vectors++;
      if (obs_a !== expected(0) || obs_b !== expected(1)) begin
        miscompares++;
        $display("[TB] FAIL win_hit%0d: got %h/%h want %h/%h", k, obs_a, obs_b, expected(0), expected(1));
      end
      step();
    end
    vectors++;
    if ({tens_a, ones_a, win_a} !== {4'd1, 4'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL win_level: got %h want %h", {tens_a, ones_a, win_a}, {4'd1, 4'd0, 1'b1});
    end
    for (int k = 0; k < 3; k++) begin
      random_target(); head_on_target(); tick = 1'b1;
      step();
      tick = 1'b0;
      vectors++;
      if (obs_a !== expected(0) || reached_a !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL after_win: got %h want %h", obs_a, expected(0));
      end
      step();
    end
  endtask

  task automatic test_saturation();
    msm = 2'b00; step();
    msm = 2'b01; step();
    for (int k = 0; k < 100; k++) begin
      random_target(); head_on_target(); tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      vectors++;
      if (obs_a !== expected(0) || obs_b !== expected(1)) begin
        miscompares++;
        $display("[TB] FAIL saturate%0d: got %h/%h want %h/%h", k, obs_a, obs_b, expected(0), expected(1));
      end
    end
    vectors++;
    if ({tens_b, ones_b, len_b, win_b} !== {4'd9, 4'd9, 8'd32, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL saturate_final: got %h want %h", {tens_b, ones_b, len_b, win_b}, {4'd9, 4'd9, 8'd32, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    msm = 2'b00; step();
    msm = 2'b01; step();
    set_target(12, 7); head_on_target(); tick = 1'b1;
    step();
    step();
    vectors++;
    if (obs_a !== {1'b0, 4'd0, 4'd1, 8'd4, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL tick_in_hit: got %h want %h", obs_a, {1'b0, 4'd0, 4'd1, 8'd4, 1'b0});
    end
    set_target(99, 100); head_on_target();
    step();
    tick = 1'b0;
    vectors++;
    if (obs_a !== {1'b1, 4'd0, 4'd2, 8'd5, 1'b0} || obs_b !== expected(1)) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: got %h/%h want %h", obs_a, obs_b, {1'b1, 4'd0, 4'd2, 8'd5, 1'b0});
    end
    step();
  endtask

  task automatic test_idle_override();
    head_on_target(); tick = 1'b1; msm = 2'b00;
    step();
    vectors++;
    if (obs_a !== {1'b0, 4'd0, 4'd0, 8'd3, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL idle_beats_hit: got %h want %h", obs_a, {1'b0, 4'd0, 4'd0, 8'd3, 1'b0});
    end
    msm = 2'b01; tick = 1'b0; step();
    tick = 1'b1; step();
    tick = 1'b0;
    vectors++;
    if (obs_a !== expected(0) || reached_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_hit: got %h want %h", obs_a, expected(0));
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    vectors++;
    if (obs_a !== {1'b0, 4'd0, 4'd0, 8'd3, 1'b0} || obs_b !== expected(1)) begin
      miscompares++;
      $display("[TB] FAIL reset_in_hit: got %h/%h want %h", obs_a, obs_b, {1'b0, 4'd0, 4'd0, 8'd3, 1'b0});
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(99, 0);
      reset_n = (r < 2) ? 1'b0 : 1'b1;
      r = $urandom_range(99, 0);
      if (r < 93) msm = 2'b01;
      else if (r < 95) msm = 2'b00;
      else if (r < 97) msm = 2'b10;
      else msm = 2'b11;
      tick = 1'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) random_target();
      if ($urandom_range(1, 0) == 1) head_on_target();
      else begin
        head_x = 8'($urandom_range(159, 0));
        head_y = 7'($urandom_range(119, 0));
      end
      step();
      vectors++;
      if (obs_a !== expected(0) || obs_b !== expected(1)) begin
        miscompares++;
        $display("[TB] FAIL random%0d: got %h/%h want %h/%h", n, obs_a, obs_b, expected(0), expected(1));
      end
    end
    reset_n = 1'b1;
  endtask

  // test sequence
  initial begin
    test_reset();
    test_single_hit();
    test_no_tick();
    test_win();
    test_saturation();
    test_back_to_back();
    test_idle_override();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
